div_share_arb: RTL and testbench

Round-robin scheduler that shares one sequential 18-bit unsigned divider among several fish-tank datapath clients, such as the temperature averager, the pH scaler and the level-percentage unit. The block accepts per-client request/operand bundles and grants the divider to one client at a time. It sequences a start/iterate/finish cycle for that client, then returns the quotient and remainder with a one-cycle done pulse. It sits between the sensor-processing blocks and the single divider core, replacing free-running per-client dividers.

---
 rtl/div_share_arb_pkg.sv | 16 +
 rtl/div_share_arb_if.sv | 29 ++
 rtl/div_share_arb_seq_div_core.sv | 80 ++++++++
 rtl/div_share_arb.sv | 153 +++++++++++++++
 tb/tb_div_share_arb.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_share_arb_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
package div_share_pkg;

    localparam int W_DEF = 18;

    // Quotient reported for a zero divisor.
    localparam logic [W_DEF-1:0] QMAX = {W_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        REL  = 2'd3
    } state_e;

endpackage

// File: rtl/div_share_arb_if.sv
// Client-side bundle of the divider-sharing arbiter: requests, operands and shared results.
interface div_share_if
    import div_share_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int W     = W_DEF
);
    logic [N_REQ-1:0]   req_i;
    logic [N_REQ*W-1:0] dividend_i;
    logic [N_REQ*W-1:0] divisor_i;
    logic [N_REQ-1:0]   gnt_o;
    logic [N_REQ-1:0]   done_o;
    logic [W-1:0]       quotient_o;
    logic [W-1:0]       remainder_o;
    logic               dz_o;
    logic               busy_o;

    // Clients drive requests and operands.
    modport master (
        output req_i, dividend_i, divisor_i,
        input  gnt_o, done_o, quotient_o, remainder_o, dz_o, busy_o
    );

    // The arbiter consumes requests and returns results.
    modport slave (
        input  req_i, dividend_i, divisor_i,
        output gnt_o, done_o, quotient_o, remainder_o, dz_o, busy_o
    );
endinterface

// File: rtl/div_share_arb_seq_div_core.sv
// Restoring unsigned divider: one quotient bit per cycle, MSB first, W cycles per start.
// A zero divisor is never presented here; the arbiter bypasses the core for that case.
module seq_div_core
    import div_share_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o
);
    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  div_q, div_d;
    logic [W:0]    rem_q, rem_d;
    logic [W:0]    rem_sh;
    logic          take;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        rem_sh = (rem_q << 1) | {{W{1'b0}}, quo_q[W-1]};
        take   = (rem_sh >= {1'b0, div_q});
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        quo_d  = quo_q;
        div_d  = div_q;
        rem_d  = rem_q;
        if (start_i) begin
            cnt_d  = '0;
            busy_d = 1'b1;
            quo_d  = dividend_i;
            div_d  = divisor_i;
            rem_d  = '0;
        end else if (busy_q) begin
            rem_d = take ? (rem_sh - {1'b0, div_q}) : rem_sh;
            quo_d = {quo_q[W-2:0], take};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Core state registers, cleared by the system reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quo_q  <= '0;
            div_q  <= '0;
            rem_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            rem_q  <= rem_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q[W-1:0];

endmodule

// File: rtl/div_share_arb.sv
// Round-robin arbiter sharing one sequential divider among N_REQ clients.
// Each operation: grant, W iterations (or a one-cycle zero-divisor bypass), done pulse, release.
module div_share_arb
    import div_share_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int W     = W_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    div_share_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [W-1:0]     dvd_q, dvd_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [W-1:0]     quot_q, quot_d;
    logic [W-1:0]     rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [PW-1:0]    pick;
    logic [W-1:0]     pick_dvd, pick_dvs;
    logic             core_start, core_busy, core_done;
    logic [W-1:0]     core_quot, core_rem;

    // First requester found searching upward from ptr, wrapping modulo N_REQ.
    function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [PW-1:0]    ptr);
        logic [PW-1:0] win;
        logic          found;
        int            idx;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[PW'(idx)]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign pick     = rr_pick(bus.req_i, ptr_q);
    assign pick_dvd = bus.dividend_i[int'(pick)*W +: W];
    assign pick_dvs = bus.divisor_i[int'(pick)*W +: W];

    seq_div_core #(.W(W)) u_core (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (core_start),
        .dividend_i  (pick_dvd),
        .divisor_i   (pick_dvs),
        .busy_o      (core_busy),
        .done_o      (core_done),
        .quotient_o  (core_quot),
        .remainder_o (core_rem)
    );

    // Sequencing: grant/latch, wait for core (or zero-divisor bypass), report, release.
    // The zero-divisor test is made on the latched divisor during the first RUN cycle,
    // so a zero-divisor operation reports one edge after the grant with the core idle.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        core_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req_i && !core_busy) begin
                    sel_d       = pick;
                    dvd_d       = pick_dvd;
                    dvs_d       = pick_dvs;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    core_start  = (pick_dvs != '0);
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (dvs_q == '0) begin
                    quot_d  = {W{1'b1}};
                    rem_d   = dvd_q;
                    dz_d    = 1'b1;
                    done_d  = gnt_q;
                    state_d = FIN;
                end else if (core_done) begin
                    quot_d  = core_quot;
                    rem_d   = core_rem;
                    dz_d    = 1'b0;
                    done_d  = gnt_q;
                    state_d = FIN;
                end
            end
            FIN: begin
                ptr_d   = (sel_q == PW'(N_REQ - 1)) ? '0 : sel_q + PW'(1);
                state_d = REL;
            end
            REL: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter registers; reset aborts any operation in flight without a done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.done_o      = done_q;
    assign bus.quotient_o  = quot_q;
    assign bus.remainder_o = rem_q;
    assign bus.dz_o        = dz_q;
    assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_div_share_arb.sv
// Bench for div_share_arb: directed scenarios plus randomized operations against a plain-arithmetic model.
module tb_div_share_arb;
    localparam int N = 3;
    localparam int W = 18;

    logic clk;
    logic rstn;

    div_share_if #(.N_REQ(N), .W(W)) bus ();

    div_share_arb #(.N_REQ(N), .W(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];

    // Results captured by do_op
    int           r_done_n, r_gnt_fall;
    logic [N-1:0] r_gnt0, r_done, r_gnt_done, r_done_after;
    logic [W-1:0] r_q, r_r, r_q_hold;
    logic         r_dz, r_busy_at_fall;
    bit           r_timeout;

    // Events captured by collect
    int           ev_n;
    int           ev_idx [8];
    int           ev_cyc [8];
    logic [W-1:0] ev_q   [8];
    logic [W-1:0] ev_r   [8];

    // Reference model: plain unsigned division with the zero-divisor convention.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return {W{1'b1}};
        return a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return a;
        return a % b;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic drive_ops();
        for (int k = 0; k < N; k++) begin
            bus.dividend_i[k*W +: W] = opa[k];
            bus.divisor_i[k*W +: W]  = opb[k];
        end
    endtask

    task automatic do_reset(input logic [N-1:0] mask);
        rstn = 1'b0;
        bus.req_i = mask;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // One operation for client k; edge index 0 is the grant edge.
    task automatic do_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
        int wn;
        r_timeout = 1'b0;
        wn = 0;
        while (bus.busy_o !== 1'b0 && wn < 50) begin
            @(posedge clk); #1; wn++;
        end
        if (wn >= 50) r_timeout = 1'b1;
        opa[k] = a; opb[k] = b; drive_ops();
        bus.req_i = '0; bus.req_i[k] = 1'b1;
        r_done_n = -1; r_gnt_fall = -1; r_done = '0; r_gnt_done = '0;
        r_done_after = 'x; r_q_hold = 'x; r_busy_at_fall = 1'bx;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                r_gnt0 = bus.gnt_o;
                if (scramble) begin
                    opa[k] = W'($urandom); opb[k] = W'($urandom); drive_ops();
                end
            end
            if (r_done_n < 0 && bus.done_o !== '0) begin
                r_done_n = n; r_done = bus.done_o; r_gnt_done = bus.gnt_o;
                r_q = bus.quotient_o; r_r = bus.remainder_o; r_dz = bus.dz_o;
                bus.req_i[k] = 1'b0;
            end else if (r_done_n >= 0 && n == r_done_n + 1) begin
                r_done_after = bus.done_o; r_q_hold = bus.quotient_o;
            end
            if (r_done_n >= 0 && bus.gnt_o === '0) begin
                r_gnt_fall = n; r_busy_at_fall = bus.busy_o;
                break;
            end
        end
        bus.req_i = '0;
    endtask

    // Present a request mask and record up to 'want' done pulses.
    task automatic collect(input logic [N-1:0] mask, input int want, input bit hold);
        int cyc;
        ev_n = 0;
        for (int i = 0; i < 8; i++) begin
            ev_idx[i] = -1; ev_cyc[i] = -1; ev_q[i] = 'x; ev_r[i] = 'x;
        end
        bus.req_i = mask;
        cyc = 0;
        while (ev_n < want && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (bus.done_o !== '0) begin
                ev_idx[ev_n] = oh_idx(bus.done_o);
                ev_cyc[ev_n] = cyc;
                ev_q[ev_n] = bus.quotient_o;
                ev_r[ev_n] = bus.remainder_o;
                ev_n++;
                if (!hold) bus.req_i = bus.req_i & ~bus.done_o;
            end
        end
        bus.req_i = '0;
    endtask

    task automatic test_reset();
        do_reset('0);
        n_chk++; if (bus.gnt_o !== '0) $display("FAIL reset_gnt got %b want 000", bus.gnt_o); else n_pass++;
        n_chk++; if (bus.done_o !== '0) $display("FAIL reset_done got %b want 000", bus.done_o); else n_pass++;
        n_chk++; if ({bus.quotient_o, bus.remainder_o, bus.dz_o} !== '0)
            $display("FAIL reset_results got q=%0d r=%0d dz=%b want 0", bus.quotient_o, bus.remainder_o, bus.dz_o); else n_pass++;
        n_chk++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy_o); else n_pass++;
    endtask

    task automatic test_single();
        do_op(0, 18'd100, 18'd7, 1'b0);
        n_chk++; if (r_gnt0 !== 3'b001) $display("FAIL single_gnt_e0 got %b want 001", r_gnt0); else n_pass++;
        n_chk++; if (r_done_n != 19) $display("FAIL single_done_edge got %0d want 19", r_done_n); else n_pass++;
        n_chk++; if (r_done !== 3'b001) $display("FAIL single_done got %b want 001", r_done); else n_pass++;
        n_chk++; if (r_q !== 18'd14) $display("FAIL single_q got %0d want 14", r_q); else n_pass++;
        n_chk++; if (r_r !== 18'd2) $display("FAIL single_r got %0d want 2", r_r); else n_pass++;
        n_chk++; if (r_dz !== 1'b0) $display("FAIL single_dz got %b want 0", r_dz); else n_pass++;
        n_chk++; if (r_gnt_done !== 3'b001) $display("FAIL single_gnt_at_done got %b want 001", r_gnt_done); else n_pass++;
        n_chk++; if (r_done_after !== 3'b000) $display("FAIL single_done_pulse got %b want 000", r_done_after); else n_pass++;
        n_chk++; if (r_q_hold !== 18'd14) $display("FAIL single_q_hold got %0d want 14", r_q_hold); else n_pass++;
        n_chk++; if (r_gnt_fall != 21) $display("FAIL single_gnt_fall got %0d want 21", r_gnt_fall); else n_pass++;
        n_chk++; if (r_busy_at_fall !== 1'b0) $display("FAIL single_busy_idle got %b want 0", r_busy_at_fall); else n_pass++;
    endtask

    task automatic test_div_zero();
        do_op(1, 18'd50, 18'd0, 1'b0);
        n_chk++; if (r_gnt0 !== 3'b010) $display("FAIL dz_gnt_e0 got %b want 010", r_gnt0); else n_pass++;
        n_chk++; if (r_done_n != 1) $display("FAIL dz_done_edge got %0d want 1", r_done_n); else n_pass++;
        n_chk++; if (r_done !== 3'b010) $display("FAIL dz_done got %b want 010", r_done); else n_pass++;
        n_chk++; if (r_q !== 18'h3FFFF) $display("FAIL dz_q got %h want 3ffff", r_q); else n_pass++;
        n_chk++; if (r_r !== 18'd50) $display("FAIL dz_r got %0d want 50", r_r); else n_pass++;
        n_chk++; if (r_dz !== 1'b1) $display("FAIL dz_flag got %b want 1", r_dz); else n_pass++;
        n_chk++; if (r_gnt_fall != 3) $display("FAIL dz_gnt_fall got %0d want 3", r_gnt_fall); else n_pass++;
    endtask

    task automatic test_edges();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        ta[0] = 18'd262143; tb[0] = 18'd1;
        ta[1] = 18'd5;      tb[1] = 18'd9;
        ta[2] = 18'd262143; tb[2] = 18'd262143;
        for (int i = 0; i < 3; i++) begin
            do_op(i, ta[i], tb[i], 1'b0);
            n_chk++; if (r_q !== ref_q(ta[i], tb[i]))
                $display("FAIL edge_q[%0d] got %0d want %0d", i, r_q, ref_q(ta[i], tb[i])); else n_pass++;
            n_chk++; if (r_r !== ref_r(ta[i], tb[i]))
                $display("FAIL edge_r[%0d] got %0d want %0d", i, r_r, ref_r(ta[i], tb[i])); else n_pass++;
            n_chk++; if (r_done_n != W + 1) $display("FAIL edge_done_edge[%0d] got %0d want %0d", i, r_done_n, W + 1); else n_pass++;
        end
    endtask

    task automatic test_operand_latch();
        do_op(2, 18'd1000, 18'd3, 1'b1);
        n_chk++; if (r_q !== 18'd333) $display("FAIL latch_q got %0d want 333", r_q); else n_pass++;
        n_chk++; if (r_r !== 18'd1) $display("FAIL latch_r got %0d want 1", r_r); else n_pass++;
        do_op(0, 18'd77, 18'd0, 1'b1);
        n_chk++; if (r_r !== 18'd77 || r_dz !== 1'b1)
            $display("FAIL latch_dz got r=%0d dz=%b want r=77 dz=1", r_r, r_dz); else n_pass++;
    endtask

    task automatic test_rr_all();
        int ord [4];
        ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 0;
        opa[0] = 18'd1000; opb[0] = 18'd3;
        opa[1] = 18'd2000; opb[1] = 18'd7;
        opa[2] = 18'd3000; opb[2] = 18'd11;
        drive_ops();
        do_reset(3'b111);
        collect(3'b111, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (ev_idx[i] != ord[i]) $display("FAIL rr_all_order[%0d] got %0d want %0d", i, ev_idx[i], ord[i]); else n_pass++;
            n_chk++; if (ev_q[i] !== ref_q(opa[ord[i]], opb[ord[i]]) || ev_r[i] !== ref_r(opa[ord[i]], opb[ord[i]]))
                $display("FAIL rr_all_result[%0d] got q=%0d r=%0d want q=%0d r=%0d", i, ev_q[i], ev_r[i],
                         ref_q(opa[ord[i]], opb[ord[i]]), ref_r(opa[ord[i]], opb[ord[i]])); else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (ev_cyc[i+1] - ev_cyc[i] != W + 4)
                $display("FAIL rr_all_spacing[%0d] got %0d want %0d", i, ev_cyc[i+1] - ev_cyc[i], W + 4); else n_pass++;
        end
    endtask

    task automatic test_rr_pointer();
        do_reset('0);
        do_op(0, 18'd10, 18'd3, 1'b0);
        n_chk++; if (r_done !== 3'b001) $display("FAIL rr_ptr_first got %b want 001", r_done); else n_pass++;
        opa[0] = 18'd40; opb[0] = 18'd6;
        opa[1] = 18'd90; opb[1] = 18'd4;
        drive_ops();
        collect(3'b011, 2, 1'b0);
        n_chk++; if (ev_idx[0] != 1) $display("FAIL rr_ptr_grant0 got %0d want 1", ev_idx[0]); else n_pass++;
        n_chk++; if (ev_idx[1] != 0) $display("FAIL rr_ptr_grant1 got %0d want 0", ev_idx[1]); else n_pass++;
        n_chk++; if (ev_q[0] !== 18'd22 || ev_r[0] !== 18'd2)
            $display("FAIL rr_ptr_result0 got q=%0d r=%0d want q=22 r=2", ev_q[0], ev_r[0]); else n_pass++;
        n_chk++; if (ev_q[1] !== 18'd6 || ev_r[1] !== 18'd4)
            $display("FAIL rr_ptr_result1 got q=%0d r=%0d want q=6 r=4", ev_q[1], ev_r[1]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        do_op(1, 18'd77, 18'd5, 1'b0);
        opa[2] = 18'd1234; opb[2] = 18'd10; drive_ops();
        bus.req_i = 3'b100;
        saw_done = 1'b0;
        for (int n = 0; n <= 10; n++) begin
            @(posedge clk); #1;
            if (bus.done_o !== '0) saw_done = 1'b1;
        end
        rstn = 1'b0;
        bus.req_i = '0;
        #1;
        n_chk++; if (bus.gnt_o !== '0 || bus.done_o !== '0 || bus.busy_o !== 1'b0)
            $display("FAIL midrst_ctrl got gnt=%b done=%b busy=%b want 0", bus.gnt_o, bus.done_o, bus.busy_o); else n_pass++;
        n_chk++; if (bus.quotient_o !== '0 || bus.remainder_o !== '0 || bus.dz_o !== 1'b0)
            $display("FAIL midrst_results got q=%0d r=%0d dz=%b want 0", bus.quotient_o, bus.remainder_o, bus.dz_o); else n_pass++;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.done_o !== '0) saw_done = 1'b1;
        end
        rstn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done_o !== '0) saw_done = 1'b1;
        end
        n_chk++; if (saw_done) $display("FAIL midrst_no_done got 1 want 0"); else n_pass++;
        opa[0] = 18'd600; opb[0] = 18'd7; drive_ops();
        collect(3'b101, 1, 1'b0);
        n_chk++; if (ev_idx[0] != 0) $display("FAIL midrst_ptr_grant got %0d want 0", ev_idx[0]); else n_pass++;
        n_chk++; if (ev_q[0] !== 18'd85 || ev_r[0] !== 18'd5)
            $display("FAIL midrst_result got q=%0d r=%0d want q=85 r=5", ev_q[0], ev_r[0]); else n_pass++;
    endtask

    task automatic test_random();
        int           k;
        int           mode;
        logic [W-1:0] a, b;
        for (int t = 0; t < 16; t++) begin
            k = $urandom_range(0, N - 1);
            a = W'($urandom);
            mode = $urandom_range(0, 7);
            if (mode == 0)      b = '0;
            else if (mode < 4)  b = W'($urandom_range(1, 15));
            else                b = W'($urandom);
            if (b == 0 && mode != 0) b = 18'd1;
            do_op(k, a, b, 1'b0);
            n_chk++; if (r_timeout) $display("FAIL rnd_idle_wait[%0d] got timeout want idle", t); else n_pass++;
            n_chk++; if (r_gnt0 !== N'(1 << k)) $display("FAIL rnd_gnt[%0d] got %b want %b", t, r_gnt0, N'(1 << k)); else n_pass++;
            n_chk++; if (r_done !== N'(1 << k)) $display("FAIL rnd_done[%0d] got %b want %b", t, r_done, N'(1 << k)); else n_pass++;
            n_chk++; if (r_done_n != ((b == 0) ? 1 : W + 1))
                $display("FAIL rnd_latency[%0d] got %0d want %0d", t, r_done_n, (b == 0) ? 1 : W + 1); else n_pass++;
            n_chk++; if (r_q !== ref_q(a, b) || r_r !== ref_r(a, b) || r_dz !== (b == 0))
                $display("FAIL rnd_result[%0d] %0d/%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                         t, a, b, r_q, r_r, r_dz, ref_q(a, b), ref_r(a, b), (b == 0)); else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "simulation stalled");
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rstn = 1'b0;
        bus.req_i = '0;
        bus.dividend_i = '0;
        bus.divisor_i = '0;
        for (int k = 0; k < N; k++) begin
            opa[k] = '0; opb[k] = '0;
        end
        test_reset();
        test_single();
        test_div_zero();
        test_edges();
        test_operand_latch();
        test_rr_all();
        test_rr_pointer();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
